step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pkg.sv | 18 +
 rtl/sync_2ff.sv | 36 +++
 rtl/step_pulse_gen.sv | 128 ++++++++++++
 tb/tb_step_pulse_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
//   Shared types and default constants for the single-step key pulse generator.
//   Holds the FSM state enum and the default hold/repeat cycle counts
//   (0.5 s hold and 0.1 s repeat at a 100 MHz CLK).
// -----------------------------------------------------------------------------
package step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } stepState_e;

    localparam logic [31:0] DEFAULT_HOLD_CYCLES   = 32'd50_000_000;
    localparam logic [31:0] DEFAULT_REPEAT_CYCLES = 32'd10_000_000;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Both flops reset
//   asynchronously to RESET_VALUE so the output is defined during reset.
//
//   Ports
//     CLK      in   destination clock
//     Reset    in   asynchronous active-high reset
//     dataIn   in   asynchronous level
//     dataOut  out  level synchronized to CLK (two-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic CLK,
    input  logic Reset,
    input  logic dataIn,
    output logic dataOut
);

    logic metaStage;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            metaStage <= RESET_VALUE;
            dataOut   <= RESET_VALUE;
        end else begin
            metaStage <= dataIn;
            dataOut   <= metaStage;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//   Converts a debounced key level into single-cycle CPU step strobes. A fresh
//   press issues one pulse; with auto-repeat compiled in, holding the key for
//   HOLD_CYCLES issues a pulse and then one more every REPEAT_CYCLES until
//   release. StepEn gates pulses and counting but never the FSM or timer.
//
//   Build option
//     STEP_AUTO_REPEAT_EN  defined: PRESS -> REPEAT after HOLD_CYCLES.
//                          undefined: one pulse per press, REPEAT unreachable.
//
//   Ports
//     CLK        in   100 MHz system clock
//     Reset      in   asynchronous active-high reset
//     KeyIn      in   debounced key level, asynchronous to CLK
//     StepEn     in   synchronous pulse/count enable
//     StepPulse  out  registered single-cycle step strobe
//     StepCount  out  registered 16-bit count of issued pulses (wraps)
//     KeyHeld    out  registered, high while in PRESS or REPEAT
// -----------------------------------------------------------------------------
module step_pulse_gen
    import step_pkg::*;
#(
    parameter logic [31:0] HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter logic [31:0] REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        KeyIn,
    input  logic        StepEn,
    output logic        StepPulse,
    output logic [15:0] StepCount,
    output logic        KeyHeld
);

    logic        ks;
    logic        prevKs;
    stepState_e  state;
    stepState_e  nextState;
    logic [31:0] timer;
    logic [31:0] nextTimer;
    logic        pulseNext;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_keySync (
        .CLK     (CLK),
        .Reset   (Reset),
        .dataIn  (KeyIn),
        .dataOut (ks)
    );

    // prevKs resets to 1 (as does the synchronizer) so a key that is already
    // down when reset releases is not seen as a rising edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            timer     <= '0;
            prevKs    <= 1'b1;
            StepPulse <= 1'b0;
            StepCount <= '0;
            KeyHeld   <= 1'b0;
        end else begin
            state     <= nextState;
            timer     <= nextTimer;
            prevKs    <= ks;
            StepPulse <= pulseNext;
            StepCount <= StepCount + {15'd0, pulseNext};
            KeyHeld   <= (nextState != IDLE);
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        nextTimer = timer;
        pulseNext = 1'b0;

        case (state)
            IDLE: begin
                nextTimer = '0;
                if (ks && !prevKs) begin
                    nextState = PRESS;
                    pulseNext = StepEn;
                end
            end

            PRESS: begin
                if (!ks) begin
                    nextState = IDLE;
                    nextTimer = '0;
                end else if (timer == HOLD_CYCLES - 32'd1) begin
`ifdef STEP_AUTO_REPEAT_EN
                    nextState = REPEAT;
                    nextTimer = '0;
                    pulseNext = StepEn;
`else
                    // Saturate: stay in PRESS until release, never wrap.
                    nextTimer = timer;
`endif
                end else begin
                    nextTimer = timer + 32'd1;
                end
            end

            // Only reachable when auto-repeat is compiled in. Release is
            // tested first so it wins over a coincident repeat expiry.
            REPEAT: begin
                if (!ks) begin
                    nextState = IDLE;
                    nextTimer = '0;
                end else if (timer == REPEAT_CYCLES - 32'd1) begin
                    nextTimer = '0;
                    pulseNext = StepEn;
                end else begin
                    nextTimer = timer + 32'd1;
                end
            end

            default: begin
                nextState = IDLE;
                nextTimer = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//   Self-checking bench for step_pulse_gen (HOLD_CYCLES=8, REPEAT_CYCLES=4).
//   A reference model predicts StepPulse/StepCount/KeyHeld from the key
//   history: KeyIn reaches the decision logic two edges late, a press starts
//   on a 0->1 of that delayed level, and repeat pulses fall at press ages
//   HOLD, HOLD+REPEAT, ... while the delayed level stays high.
//   Honours STEP_AUTO_REPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;
`ifdef STEP_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic        KeyIn;
    logic        StepEn;
    logic        StepPulse;
    logic [15:0] StepCount;
    logic        KeyHeld;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    logic        keyHist [3];   // [0] newest KeyIn sample, [1] level seen now, [2] level one edge earlier
    bit          pressing;
    int          pressStart;
    int          edgeNum;
    logic        expPulse;
    logic [15:0] expCount;
    logic        expHeld;

    step_pulse_gen #(
        .HOLD_CYCLES   (32'd8),
        .REPEAT_CYCLES (32'd4)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .KeyIn     (KeyIn),
        .StepEn    (StepEn),
        .StepPulse (StepPulse),
        .StepCount (StepCount),
        .KeyHeld   (KeyHeld)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) keyHist[i] = 1'b1;
        pressing = 1'b0;
        pressStart = 0;
        expPulse = 1'b0;
        expCount = '0;
        expHeld  = 1'b0;
    endtask

    // One rising edge with Reset low, inputs as driven before the edge.
    task automatic modelEdge(input logic key, input logic en);
        logic level;
        logic levelPrev;
        int   age;
        level     = keyHist[1];
        levelPrev = keyHist[2];
        expPulse  = 1'b0;
        if (pressing) begin
            if (!level) begin
                pressing = 1'b0;
            end else if (AUTO_REPEAT) begin
                age = edgeNum - pressStart;
                if (age >= HOLD && ((age - HOLD) % REPEAT) == 0) expPulse = en;
            end
        end else if (level && !levelPrev) begin
            pressing   = 1'b1;
            pressStart = edgeNum;
            expPulse   = en;
        end
        expCount   = expCount + {15'd0, expPulse};
        expHeld    = pressing;
        keyHist[2] = keyHist[1];
        keyHist[1] = keyHist[0];
        keyHist[0] = key;
        edgeNum++;
    endtask

    task automatic checkOutputs(input string where);
        check({where, ".pulse"}, {31'd0, StepPulse}, {31'd0, expPulse});
        check({where, ".count"}, {16'd0, StepCount}, {16'd0, expCount});
        check({where, ".held"},  {31'd0, KeyHeld},   {31'd0, expHeld});
    endtask

    // Entered and left at a falling edge.
    task automatic stepCycle(input logic key, input logic en);
        KeyIn  = key;
        StepEn = en;
        @(posedge CLK);
        modelEdge(key, en);
        #1;
        checkOutputs("cycle");
        @(negedge CLK);
    endtask

    // Assert Reset mid-cycle, check the asynchronous clear, hold for some
    // edges, then release at a falling edge. KeyIn is left unchanged.
    task automatic doReset(input int holdEdges);
        #2;
        Reset = 1'b1;
        modelReset();
        #1;
        checkOutputs("rst_async");
        repeat (holdEdges) begin
            @(posedge CLK);
            #1;
            checkOutputs("rst_hold");
        end
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    logic [15:0] countBefore;

    initial begin
        Reset  = 1'b1;
        KeyIn  = 1'b0;
        StepEn = 1'b1;
        edgeNum = 0;
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset.pulse", {31'd0, StepPulse}, 32'd0);
        check("reset.count", {16'd0, StepCount}, 32'd0);
        check("reset.held",  {31'd0, KeyHeld},   32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (4) stepCycle(1'b0, 1'b1);

        // Single press held 5 cycles.
        repeat (5) stepCycle(1'b1, 1'b1);
        repeat (6) stepCycle(1'b0, 1'b1);
        check("press5.count", {16'd0, StepCount}, 32'd1);

        // Long hold: four pulses with auto-repeat, one without.
        countBefore = expCount;
        repeat (20) stepCycle(1'b1, 1'b1);
        repeat (6)  stepCycle(1'b0, 1'b1);
        check("hold20.count", {16'd0, StepCount},
              {16'd0, countBefore + (AUTO_REPEAT ? 16'd4 : 16'd1)});

        // StepEn low for the whole press: held but silent.
        countBefore = expCount;
        repeat (12) stepCycle(1'b1, 1'b0);
        check("gated.held",  {31'd0, KeyHeld},   32'd1);
        check("gated.count", {16'd0, StepCount}, {16'd0, countBefore});
        repeat (5) stepCycle(1'b0, 1'b1);

        // Reset during REPEAT with key held through release: silent until re-press.
        repeat (15) stepCycle(1'b1, 1'b1);
        doReset(1);
        repeat (12) stepCycle(1'b1, 1'b1);
        check("rst_held.count", {16'd0, StepCount}, 32'd0);
        repeat (4) stepCycle(1'b0, 1'b1);
        repeat (3) stepCycle(1'b1, 1'b1);
        check("repress.count", {16'd0, StepCount}, 32'd1);
        repeat (4) stepCycle(1'b0, 1'b1);

        // Randomized key runs with mostly-enabled StepEn and occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            logic key;
            int   len;
            key = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) stepCycle(key, ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 39) == 0) doReset($urandom_range(0, 2));
        end
        repeat (4) stepCycle(1'b0, 1'b1);

        // Drive the counter up to 0xFFFF with fast presses, then wrap it.
        while (expCount < 16'hFFF0) begin
            stepCycle(1'b1, 1'b1);
            stepCycle(1'b0, 1'b1);
        end
        repeat (3) stepCycle(1'b0, 1'b1);
        while (expCount != 16'hFFFF) begin
            stepCycle(1'b1, 1'b1);
            stepCycle(1'b0, 1'b1);
            stepCycle(1'b0, 1'b1);
        end
        check("prewrap.count", {16'd0, StepCount}, 32'h0000_FFFF);
        stepCycle(1'b1, 1'b1);
        stepCycle(1'b0, 1'b1);
        stepCycle(1'b0, 1'b1);
        check("wrap.pulse", {31'd0, StepPulse}, 32'd1);
        check("wrap.count", {16'd0, StepCount}, 32'd0);
        repeat (3) stepCycle(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
